// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared fetch FSM states, reset vector and instruction length type.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [2:0] {
        VEC_LO = 3'd0,
        VEC_HI = 3'd1,
        OP     = 3'd2,
        OPR1   = 3'd3,
        OPR2   = 3'd4,
        ISSUE  = 3'd5,
        DRAIN  = 3'd6
    } fetch_state_e;

    localparam logic [15:0] VEC_RESET = 16'hFFFC;

    typedef logic [1:0] instr_len_t;

    localparam instr_len_t LEN1 = 2'd1;
    localparam instr_len_t LEN2 = 2'd2;
    localparam instr_len_t LEN3 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/instr_len_lut.sv
// ============================================================================
//  Module      : instr_len_lut
//  Description : Combinational opcode -> bundle length (1..3 bytes) table.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_len_lut
    import cpu_pkg::*;
(
    input  logic [7:0]  op_i,
    output instr_len_t  len_o
);

    always_comb begin
        len_o = LEN2;
        // Low nibble C..F is exactly op_i[3:2] == 2'b11.
        if (op_i == 8'h20 || op_i[4:0] == 5'b11001 || op_i[3:2] == 2'b11) begin
            len_o = LEN3;
        end else if (op_i == 8'h00 || op_i == 8'h40 || op_i == 8'h60 ||
                     op_i[3:0] == 4'h8 || op_i[3:0] == 4'hA) begin
            len_o = LEN1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Byte-serial instruction fetcher with reset vector, redirect and drain.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_op,
    output logic [7:0]  instr_lo,
    output logic [7:0]  instr_hi,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    input  logic        redir_valid,
    input  logic [15:0] redir_pc
);

    fetch_state_e state_q;
    logic [15:0]  pc_q;
    logic         mem_req_q;
    logic [15:0]  mem_addr_q;
    logic         instr_valid_q;
    logic [7:0]   op_q;
    logic [7:0]   lo_q;
    logic [7:0]   hi_q;
    instr_len_t   len_q;
    logic [15:0]  ipc_q;

    instr_len_t   lut_len;
    logic [15:0]  pc_inc;

    assign pc_inc = pc_q + 16'd1;

    instr_len_lut u_len_lut (
        .op_i  (mem_rdata),
        .len_o (lut_len)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= VEC_LO;
            pc_q          <= VEC_RESET;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= VEC_RESET;
            instr_valid_q <= 1'b0;
            op_q          <= 8'h00;
            lo_q          <= 8'h00;
            hi_q          <= 8'h00;
            len_q         <= 2'd0;
            ipc_q         <= 16'h0000;
        end else begin
            case (state_q)
                VEC_LO: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= VEC_RESET;
                    end else if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        pc_q[7:0]  <= mem_rdata;
                        state_q    <= VEC_HI;
                    end
                end
                VEC_HI: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= VEC_RESET + 16'd1;
                    end else if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        pc_q[15:8] <= mem_rdata;
                        state_q    <= OP;
                    end
                end
                OP, OPR1, OPR2: begin
                    if (redir_valid) begin
                        // An outstanding read must still complete; DRAIN swallows it.
                        pc_q <= redir_pc;
                        if (mem_req_q && !mem_ack) begin
                            state_q <= DRAIN;
                        end else begin
                            mem_req_q <= 1'b0;
                            state_q   <= OP;
                        end
                    end else if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        pc_q      <= pc_inc;
                        if (state_q == OP) begin
                            op_q  <= mem_rdata;
                            lo_q  <= 8'h00;
                            hi_q  <= 8'h00;
                            ipc_q <= pc_q;
                            len_q <= lut_len;
                            if (lut_len == LEN1) begin
                                instr_valid_q <= 1'b1;
                                state_q       <= ISSUE;
                            end else begin
                                state_q <= OPR1;
                            end
                        end else if (state_q == OPR1) begin
                            lo_q <= mem_rdata;
                            if (len_q == LEN3) begin
                                state_q <= OPR2;
                            end else begin
                                instr_valid_q <= 1'b1;
                                state_q       <= ISSUE;
                            end
                        end else begin
                            hi_q          <= mem_rdata;
                            instr_valid_q <= 1'b1;
                            state_q       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (redir_valid) begin
                        pc_q          <= redir_pc;
                        instr_valid_q <= 1'b0;
                        state_q       <= OP;
                    end else if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= OP;
                    end
                end
                DRAIN: begin
                    if (redir_valid) begin
                        pc_q <= redir_pc;
                    end
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= OP;
                    end
                end
                default: begin
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    state_q       <= VEC_LO;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr_op    = op_q;
    assign instr_lo    = lo_q;
    assign instr_hi    = hi_q;
    assign instr_len   = len_q;
    assign instr_pc    = ipc_q;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The fetch_unit SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mem_req  output  1  read request; held high until mem_ack.
REQ-005 mem_addr  output  16  byte address; stable while mem_req is high.
REQ-006 mem_ack  input  1  read complete; mem_rdata valid in the same cycle.
REQ-007 mem_rdata  input  8  read data.
REQ-008 instr_valid  output  1  fetched instruction bundle is available.
REQ-009 instr_ready  input  1  decoder accepts the bundle.
REQ-010 instr_op, instr_lo, instr_hi  output  8 each  opcode, operand byte 1 and operand byte 2.
REQ-011 instr_len  output  2  bundle length in bytes, 1..3.
REQ-012 instr_pc  output  16  address of the opcode byte.
REQ-013 redir_valid  input  1  one-cycle redirect pulse for a branch, jump or interrupt.
REQ-014 redir_pc  input  16  new fetch address; sampled when redir_valid is high.

Function
REQ-015 The FSM SHALL have the states VEC_LO, VEC_HI, OP, OPR1, OPR2, ISSUE, DRAIN.
REQ-016 On leaving reset the unit SHALL be in VEC_LO and read 0xFFFC, then 0xFFFD in VEC_HI; PC = {hi, lo}; then go to OP.
REQ-017 OP: read mem[PC]; on mem_ack capture instr_op, set instr_pc = PC, PC = PC+1, and compute len via instr_len_lut.
REQ-018 After OP the next state SHALL be len==1 -> ISSUE, else OPR1.
REQ-019 OPR1 reads mem[PC] into instr_lo, PC+1, then goes to OPR2 if len==3, else ISSUE.
REQ-020 OPR2 reads mem[PC] into instr_hi, PC+1, then goes to ISSUE.
REQ-021 Unused operand bytes SHALL read 0x00.
REQ-022 In ISSUE, instr_valid SHALL be 1; the bundle outputs SHALL be stable until instr_valid && instr_ready; the unit then goes to OP in the next cycle.
REQ-023 Fetch latency: at most one idle cycle between a mem_ack and the next mem_req.
REQ-024 mem_req SHALL be 0 in ISSUE; there is no prefetch.
REQ-025 PC arithmetic SHALL be 16-bit modulo: 0xFFFF+1 = 0x0000, with no error.
REQ-026 Length table (decided):
  - 1 byte: 0x00, 0x40, 0x60, and all opcodes with low nibble 0x8 or 0xA.
  - 3 bytes: 0x20, all xxx11001 opcodes, and all opcodes with low nibble 0xC, 0xD, 0xE or 0xF.
  - 2 bytes: all others (includes xxx01001, 0xA0, 0xA2, 0xC0, 0xE0).
REQ-027 redir_valid in OP, OPR1 or OPR2 SHALL load PC = redir_pc and discard the partial bundle.
REQ-028 If that redirect arrives with mem_req high and no mem_ack in the same cycle, the unit SHALL go to DRAIN, keep mem_req and mem_addr unchanged, and discard the data; on mem_ack it goes to OP.
REQ-029 If that redirect arrives in the same cycle as mem_ack, the data SHALL be discarded and the next state is OP.
REQ-030 redir_valid in ISSUE SHALL drop instr_valid in the next cycle even if instr_ready is high in the same cycle; the bundle counts as not accepted.
REQ-031 redir_valid in VEC_LO or VEC_HI SHALL be ignored.
REQ-032 redir_valid in DRAIN SHALL update the pending PC only.

Reset
REQ-033 While rst_n is low: state = VEC_LO, PC = 0xFFFC, mem_req = 0, instr_valid = 0, all bundle outputs = 0.
REQ-034 The first mem_req SHALL assert in the first cycle after reset deassertion.
REQ-035 Reset asserted mid-transaction SHALL abandon it immediately, with no drain.

Structure
REQ-036 A shared package (cpu_pkg) SHALL hold the FSM state enum, VEC_RESET = 16'hFFFC, and the instr_len_t type.
REQ-037 The length table SHALL be a combinational sub-module, instr_len_lut (8-bit opcode in, 2-bit length out), reusable by the decoder.

Verification
REQ-038 Reset vector: mem[FFFC]=0x00, mem[FFFD]=0x80 -> first OP read at 0x8000.
REQ-039 Immediate instruction: 0xA9 0x42 at 0x8000, instr_ready=1 -> bundle op=A9, lo=42, hi=00, len=2, pc=8000; next opcode read at 0x8002.
REQ-040 Decoder backpressure with a 3-byte instruction: 0x4C 0x34 0x12, instr_ready held 0 for 5 cycles -> outputs stable, mem_req=0 throughout; the fetch at 0x8003 follows the accepting handshake.
REQ-041 Redirect while memory is busy: redir_valid with redir_pc=0x9000 in OPR1 while mem_ack is delayed 3 cycles -> DRAIN until ack, no bundle issued, next read at 0x9000.
REQ-042 Address wrap: 1-byte 0xEA at 0xFFFF -> pc=FFFF, next fetch at 0x0000.
REQ-043 Reset mid-fetch: rst_n low during OPR2 -> mem_req=0 immediately; after release, refetch at 0xFFFC.
